ps2_mouse_responder: RTL

- Device-side PS/2 mouse behavioural responder. It is the counterpart of the host-side mouse controller.
- Takes command bytes decoded by a device-side PS/2 byte receiver and answers through a device-side byte transmitter. Replies are ACK, BAT result, device ID or resend.
- When data reporting is enabled, it packs movement/button requests into standard 3-byte stream packets.
- Used as an on-chip loopback target for host-controller bring-up and as a bench model.

---
 rtl/ps2_mouse_responder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_responder.sv
// PS/2 mouse device model: decodes host commands, replies through a byte transmitter, packs 3-byte stream packets.
// Replies strobe >=2 cycles after the command/accept; each byte waits for tx_ready and is followed by a 1-cycle gap.
module ps2_mouse_responder #(
  parameter logic [15:0] RESET_DELAY = 16'h1000,
  parameter logic [7:0]  DEVICE_ID   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  input  logic       tx_ready,
  output logic       tx_stb,
  output logic [7:0] tx_data,
  input  logic       mv_valid,
  output logic       mv_ready,
  input  logic [9:0] mv_dx,
  input  logic [9:0] mv_dy,
  input  logic [2:0] mv_btn,
  output logic       stream_en,
  output logic       bad_cmd
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DECODE, ST_SEND_ACK, ST_BAT_WAIT, ST_SEND_AA, ST_SEND_ID,
    ST_SEND_RESEND, ST_PKT_1, ST_PKT_2, ST_PKT_3, ST_TX_GAP
  } state_t;

  typedef enum logic [1:0] {AFT_IDLE, AFT_BAT, AFT_ID} after_t;
  typedef enum logic [1:0] {SE_KEEP, SE_SET, SE_CLR} se_act_t;

  state_t      state_q, state_d, ret_q, ret_d, send_ret;
  after_t      after_q, after_d;
  se_act_t     se_act_q, se_act_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  last_tx_q, last_tx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_stb_q, tx_stb_d;
  logic        stream_q, stream_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  retx_q, retx_d;
  logic [7:0]  pkt1_q, pkt1_d, pkt2_q, pkt2_d, pkt3_q, pkt3_d;
  logic        run_q;
  logic [7:0]  send_byte;
  logic        send_go;
  logic [9:0]  x_enc, y_enc;

  // Returns {ovf, sign, data}: 10-bit signed delta saturated into the 9-bit PS/2 range.
  function automatic logic [9:0] ps2_enc(input logic [9:0] v);
    if (!v[9] && v[8])      return {1'b1, 1'b0, 8'hFF};
    else if (v[9] && !v[8]) return {1'b1, 1'b1, 8'h00};
    else                    return {1'b0, v[8], v[7:0]};
  endfunction

  assign x_enc     = ps2_enc(mv_dx);
  assign y_enc     = ps2_enc(mv_dy);
  assign tx_stb    = tx_stb_q;
  assign tx_data   = tx_data_q;
  assign stream_en = stream_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      after_q   <= AFT_IDLE;
      se_act_q  <= SE_KEEP;
      cmd_q     <= 8'h00;
      last_tx_q <= 8'h00;
      tx_data_q <= 8'h00;
      tx_stb_q  <= 1'b0;
      stream_q  <= 1'b0;
      cnt_q     <= 16'h0000;
      retx_q    <= 8'h00;
      pkt1_q    <= 8'h00;
      pkt2_q    <= 8'h00;
      pkt3_q    <= 8'h00;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      after_q   <= after_d;
      se_act_q  <= se_act_d;
      cmd_q     <= cmd_d;
      last_tx_q <= last_tx_d;
      tx_data_q <= tx_data_d;
      tx_stb_q  <= tx_stb_d;
      stream_q  <= stream_d;
      cnt_q     <= cnt_d;
      retx_q    <= retx_d;
      pkt1_q    <= pkt1_d;
      pkt2_q    <= pkt2_d;
      pkt3_q    <= pkt3_d;
      run_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    after_d   = after_q;
    se_act_d  = se_act_q;
    cmd_d     = cmd_q;
    last_tx_d = last_tx_q;
    tx_data_d = tx_data_q;
    tx_stb_d  = 1'b0;
    stream_d  = stream_q;
    cnt_d     = (cnt_q != 16'h0000) ? cnt_q - 16'd1 : cnt_q;
    retx_d    = retx_q;
    pkt1_d    = pkt1_q;
    pkt2_d    = pkt2_q;
    pkt3_d    = pkt3_q;
    send_byte = 8'h00;
    send_go   = 1'b0;
    send_ret  = ST_IDLE;

    if (cmd_valid) begin
      cmd_d   = cmd_data;
      state_d = ST_DECODE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mv_valid && mv_ready && stream_q) begin
            pkt1_d  = {y_enc[9], x_enc[9], y_enc[8], x_enc[8], 1'b1, mv_btn};
            pkt2_d  = x_enc[7:0];
            pkt3_d  = y_enc[7:0];
            state_d = ST_PKT_1;
          end
        end
        ST_DECODE: begin
          after_d  = AFT_IDLE;
          se_act_d = SE_KEEP;
          state_d  = ST_SEND_ACK;
          case (cmd_q)
            8'hFF:        begin after_d = AFT_BAT; se_act_d = SE_CLR; end
            8'hF4:        se_act_d = SE_SET;
            8'hF5, 8'hF6: se_act_d = SE_CLR;
            8'hEA:        se_act_d = SE_KEEP;
            8'hF2:        after_d = AFT_ID;
            8'hFE:        begin retx_d = last_tx_q; state_d = ST_SEND_RESEND; end
            default:      begin retx_d = 8'hFE;     state_d = ST_SEND_RESEND; end
          endcase
        end
        ST_SEND_ACK: begin
          send_go   = 1'b1;
          send_byte = 8'hFA;
          case (after_q)
            AFT_BAT: send_ret = ST_BAT_WAIT;
            AFT_ID:  send_ret = ST_SEND_ID;
            default: send_ret = ST_IDLE;
          endcase
          if (tx_ready) begin
            case (se_act_q)
              SE_SET:  stream_d = 1'b1;
              SE_CLR:  stream_d = 1'b0;
              default: stream_d = stream_q;
            endcase
            // The BAT counter starts at the FA strobe so AA lands RESET_DELAY+1 cycles after it.
            if (after_q == AFT_BAT) cnt_d = RESET_DELAY;
          end
        end
        ST_BAT_WAIT:    if (cnt_q <= 16'd1) state_d = ST_SEND_AA;
        ST_SEND_AA:     begin send_go = 1'b1; send_byte = 8'hAA;     send_ret = ST_SEND_ID; end
        ST_SEND_ID:     begin send_go = 1'b1; send_byte = DEVICE_ID; send_ret = ST_IDLE;    end
        ST_SEND_RESEND: begin send_go = 1'b1; send_byte = retx_q;    send_ret = ST_IDLE;    end
        ST_PKT_1:       begin send_go = 1'b1; send_byte = pkt1_q;    send_ret = ST_PKT_2;   end
        ST_PKT_2:       begin send_go = 1'b1; send_byte = pkt2_q;    send_ret = ST_PKT_3;   end
        ST_PKT_3:       begin send_go = 1'b1; send_byte = pkt3_q;    send_ret = ST_IDLE;    end
        ST_TX_GAP:      state_d = ret_q;
        default:        state_d = ST_IDLE;
      endcase

      if (send_go && tx_ready) begin
        tx_stb_d  = 1'b1;
        tx_data_d = send_byte;
        last_tx_d = send_byte;
        ret_d     = send_ret;
        state_d   = ST_TX_GAP;
      end
    end
  end

  always_comb begin
    mv_ready = run_q && (state_q == ST_IDLE) && !cmd_valid;
    bad_cmd  = 1'b0;
    if (state_q == ST_DECODE) begin
      case (cmd_q)
        8'hFF, 8'hF4, 8'hF5, 8'hF6, 8'hEA, 8'hF2, 8'hFE: bad_cmd = 1'b0;
        default:                                         bad_cmd = 1'b1;
      endcase
    end
  end

endmodule
